// File: rtl/jump_charge_ctrl_pkg.sv
// Shared state encoding and widths for the jump charge controller.
package jump_charge_ctrl_pkg;

   localparam int JUMP_DIST_W = 8;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_CHARGE   = 3'd1,
      ST_HOLD     = 3'd2,
      ST_COOLDOWN = 3'd3,
      ST_LOCKED   = 3'd4
   } state_t;

endpackage

// File: rtl/jump_charge_ctrl_btn_debounce.sv
// Two-flop synchroniser plus stability counter; level follows raw after
// DEBOUNCE_CYC consecutive differing synced samples (about DEBOUNCE_CYC+2 cycles).
module btn_debounce #(
   parameter int DEBOUNCE_CYC = 500000
) (
   input  logic clk,
   input  logic restart,
   input  logic raw,
   output logic level
);

   localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

   logic             sync_a;
   logic             sync_b;
   logic [CNT_W-1:0] stable_cnt;

   always_ff @(posedge clk) begin
      if (restart) begin
         sync_a     <= 1'b0;
         sync_b     <= 1'b0;
         stable_cnt <= '0;
         level      <= 1'b0;
      end else begin
         sync_a <= raw;
         sync_b <= sync_a;
         // Counter only runs while the synced input disagrees with the current level.
         if (sync_b != level) begin
            if (stable_cnt == CNT_W'(DEBOUNCE_CYC - 1)) begin
               level      <= sync_b;
               stable_cnt <= '0;
            end else begin
               stable_cnt <= stable_cnt + CNT_W'(1);
            end
         end else begin
            stable_cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/jump_charge_ctrl.sv
// Game tick generator and button-driven jump charge FSM; all outputs registered,
// FSM outputs change on entry to the tick-high cycle.
module jump_charge_ctrl
   import jump_charge_ctrl_pkg::*;
#(
   parameter int TICK_DIV       = 2000000,
   parameter int DEBOUNCE_CYC   = 500000,
   parameter int CHARGE_STEP    = 2,
   parameter int CHARGE_MAX     = 200,
   parameter int COOLDOWN_TICKS = 20
) (
   input  logic                   clk,
   input  logic                   restart,
   input  logic                   btn,
   input  logic                   dead,
   output logic                   tick,
   output logic [JUMP_DIST_W-1:0] jump_dist,
   output logic                   charging,
   output logic                   released
);

   localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int CD_W   = (COOLDOWN_TICKS > 0) ? $clog2(COOLDOWN_TICKS + 1) : 1;
   localparam int SUM_W  = JUMP_DIST_W + 1;

   logic [TICK_W-1:0]      tick_cnt;
   logic                   tick_adv;
   logic                   level;
   state_t                 state;
   state_t                 state_nxt;
   logic [JUMP_DIST_W-1:0] jd_nxt;
   logic [CD_W-1:0]        cd_cnt;
   logic [CD_W-1:0]        cd_nxt;
   logic                   rel_nxt;
   logic [SUM_W-1:0]       sum;

   btn_debounce #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC)
   ) u_debounce (
      .clk     (clk),
      .restart (restart),
      .raw     (btn),
      .level   (level)
   );

   // tick_adv marks the edge that makes tick_cnt reach TICK_DIV-1, so the
   // registered tick and the FSM update land in the same cycle.
   assign tick_adv = (tick_cnt == TICK_W'(TICK_DIV - 2));

   always_ff @(posedge clk) begin
      if (restart) begin
         tick_cnt <= '0;
         tick     <= 1'b0;
      end else begin
         tick <= tick_adv;
         if (tick_cnt == TICK_W'(TICK_DIV - 1)) begin
            tick_cnt <= '0;
         end else begin
            tick_cnt <= tick_cnt + TICK_W'(1);
         end
      end
   end

   always_comb begin
      state_nxt = state;
      jd_nxt    = jump_dist;
      cd_nxt    = cd_cnt;
      rel_nxt   = 1'b0;
      sum       = {1'b0, jump_dist} + SUM_W'(CHARGE_STEP);
      if (tick_adv) begin
         if (dead) begin
            state_nxt = ST_LOCKED;
            jd_nxt    = '0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (level) begin
                     state_nxt = ST_CHARGE;
                     jd_nxt    = JUMP_DIST_W'(CHARGE_STEP);
                  end
               end
               ST_CHARGE: begin
                  if (level) begin
                     if (sum > SUM_W'(CHARGE_MAX)) begin
                        jd_nxt = JUMP_DIST_W'(CHARGE_MAX);
                     end else begin
                        jd_nxt = sum[JUMP_DIST_W-1:0];
                     end
                  end else begin
                     state_nxt = ST_HOLD;
                     rel_nxt   = 1'b1;
                  end
               end
               ST_HOLD: begin
                  state_nxt = ST_COOLDOWN;
                  jd_nxt    = '0;
                  cd_nxt    = CD_W'(COOLDOWN_TICKS);
               end
               ST_COOLDOWN: begin
                  // A held button parks us here at zero; only a release re-arms IDLE.
                  if (cd_cnt != '0) begin
                     cd_nxt = cd_cnt - CD_W'(1);
                  end else if (!level) begin
                     state_nxt = ST_IDLE;
                  end
               end
               ST_LOCKED: begin
                  state_nxt = ST_LOCKED;
               end
               default: begin
                  state_nxt = ST_IDLE;
                  jd_nxt    = '0;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (restart) begin
         state     <= ST_IDLE;
         jump_dist <= '0;
         cd_cnt    <= '0;
         charging  <= 1'b0;
         released  <= 1'b0;
      end else begin
         state     <= state_nxt;
         jump_dist <= jd_nxt;
         cd_cnt    <= cd_nxt;
         charging  <= (state_nxt == ST_CHARGE);
         released  <= rel_nxt;
      end
   end

endmodule

// File: tb/tb_jump_charge_ctrl.sv
// Scenario bench for jump_charge_ctrl, checked cycle by cycle against a behavioural model.
module tb_jump_charge_ctrl;

   localparam int TD = 4;
   localparam int DB = 3;
   localparam int ST = 2;
   localparam int MX = 10;
   localparam int CD = 3;

   localparam int M_IDLE = 0;
   localparam int M_CHG  = 1;
   localparam int M_HOLD = 2;
   localparam int M_COOL = 3;
   localparam int M_LOCK = 4;

   logic       clk = 1'b0;
   logic       restart;
   logic       btn;
   logic       dead;
   logic       tick;
   logic [7:0] jump_dist;
   logic       charging;
   logic       released;

   int checks = 0;
   int errors = 0;

   jump_charge_ctrl #(
      .TICK_DIV       (TD),
      .DEBOUNCE_CYC   (DB),
      .CHARGE_STEP    (ST),
      .CHARGE_MAX     (MX),
      .COOLDOWN_TICKS (CD)
   ) dut (
      .clk       (clk),
      .restart   (restart),
      .btn       (btn),
      .dead      (dead),
      .tick      (tick),
      .jump_dist (jump_dist),
      .charging  (charging),
      .released  (released)
   );

   always #5 clk = ~clk;

   // Reference model: cycles since restart, btn sample history, charge phase.
   int m_cyc, m_run, m_phase, m_jd, m_cd;
   bit m_b1, m_b2, m_lvl, m_tick, m_rel, m_lvl_old;

   task automatic model_step();
      if (restart) begin
         m_cyc = 0; m_run = 0; m_phase = M_IDLE; m_jd = 0; m_cd = 0;
         m_b1 = 0; m_b2 = 0; m_lvl = 0; m_tick = 0; m_rel = 0;
      end else begin
         m_lvl_old = m_lvl;
         if (m_b2 != m_lvl) begin
            m_run++;
            if (m_run == DB) begin
               m_lvl = m_b2;
               m_run = 0;
            end
         end else begin
            m_run = 0;
         end
         m_cyc++;
         m_tick = ((m_cyc % TD) == TD - 1);
         m_rel  = 0;
         if (m_tick) begin
            if (dead) begin
               m_phase = M_LOCK;
               m_jd    = 0;
            end else begin
               case (m_phase)
                  M_IDLE: if (m_lvl_old) begin m_phase = M_CHG; m_jd = ST; end
                  M_CHG: begin
                     if (m_lvl_old) m_jd = (m_jd + ST > MX) ? MX : m_jd + ST;
                     else begin m_phase = M_HOLD; m_rel = 1; end
                  end
                  M_HOLD: begin m_phase = M_COOL; m_jd = 0; m_cd = CD; end
                  M_COOL: begin
                     if (m_cd > 0) m_cd--;
                     else if (!m_lvl_old) m_phase = M_IDLE;
                  end
                  default: ;
               endcase
            end
         end
         m_b2 = m_b1;
         m_b1 = btn;
      end
   endtask

   always @(posedge clk) model_step();

   function automatic logic [10:0] m_out();
      return {m_tick, 8'(m_jd), m_phase == M_CHG, m_rel};
   endfunction

   task automatic test_reset();
      restart = 1'b1; btn = 1'b0; dead = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({tick, jump_dist, charging, released} !== 11'd0) begin
         errors++;
         $display("FAIL reset_outputs got %h exp 000", {tick, jump_dist, charging, released});
      end
      restart = 1'b0;
      for (int i = 2; i <= 12; i++) begin
         @(negedge clk);
         checks++;
         if (tick !== ((i % TD) == 0)) begin
            errors++;
            $display("FAIL tick_period cycle %0d got %b exp %b", i, tick, (i % TD) == 0);
         end
         checks++;
         if (jump_dist !== 8'd0) begin
            errors++;
            $display("FAIL idle_jump_dist cycle %0d got %0d exp 0", i, jump_dist);
         end
         checks++;
         if ({tick, jump_dist, charging, released} !== m_out()) begin
            errors++;
            $display("FAIL reset_lockstep t=%0t got %h exp %h", $time, {tick, jump_dist, charging, released}, m_out());
         end
      end
   endtask

   task automatic test_charge_release();
      logic [7:0] seen[$];
      logic [7:0] prev_jd;
      int n;
      bit got_rel;
      btn = 1'b0;
      repeat (40) begin
         @(negedge clk);
         checks++;
         if ({tick, jump_dist, charging, released} !== m_out()) begin
            errors++;
            $display("FAIL charge_lockstep t=%0t got %h exp %h", $time, {tick, jump_dist, charging, released}, m_out());
         end
      end
      btn = 1'b1;
      n = 0;
      while (charging !== 1'b1 && n < 40) begin
         @(negedge clk); n++;
         checks++;
         if ({tick, jump_dist, charging, released} !== m_out()) begin
            errors++;
            $display("FAIL charge_lockstep t=%0t got %h exp %h", $time, {tick, jump_dist, charging, released}, m_out());
         end
      end
      seen.push_back(jump_dist);
      n = 0;
      while (seen.size() < 3 && n < 40) begin
         @(negedge clk); n++;
         checks++;
         if ({tick, jump_dist, charging, released} !== m_out()) begin
            errors++;
            $display("FAIL charge_lockstep t=%0t got %h exp %h", $time, {tick, jump_dist, charging, released}, m_out());
         end
         if (tick) seen.push_back(jump_dist);
      end
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (k >= seen.size() || seen[k] !== 8'(ST * (k + 1))) begin
            errors++;
            $display("FAIL charge_ramp step %0d got %0d exp %0d", k, (k < seen.size()) ? seen[k] : 8'd0, ST * (k + 1));
         end
      end
      btn = 1'b0;
      prev_jd = jump_dist; got_rel = 0; n = 0;
      while (!got_rel && n < 60) begin
         @(negedge clk); n++;
         checks++;
         if ({tick, jump_dist, charging, released} !== m_out()) begin
            errors++;
            $display("FAIL charge_lockstep t=%0t got %h exp %h", $time, {tick, jump_dist, charging, released}, m_out());
         end
         if (released === 1'b1) got_rel = 1;
         else if (tick) prev_jd = jump_dist;
      end
      checks++;
      if (!got_rel) begin errors++; $display("FAIL release_pulse got none exp 1 pulse"); end
      checks++;
      if (jump_dist !== prev_jd || jump_dist === 8'd0) begin
         errors++;
         $display("FAIL hold_value got %0d exp %0d (nonzero)", jump_dist, prev_jd);
      end
      checks++;
      if (charging !== 1'b0) begin errors++; $display("FAIL hold_charging got %b exp 0", charging); end
      n = 0;
      do begin
         @(negedge clk); n++;
      end while (tick !== 1'b1 && n < 10);
      checks++;
      if (jump_dist !== 8'd0) begin errors++; $display("FAIL hold_drop got %0d exp 0", jump_dist); end
      repeat (24) begin
         @(negedge clk);
         checks++;
         if ({tick, jump_dist, charging, released} !== m_out()) begin
            errors++;
            $display("FAIL cooldown_lockstep t=%0t got %h exp %h", $time, {tick, jump_dist, charging, released}, m_out());
         end
      end
   endtask

   task automatic test_saturation();
      int exp_sat[8] = '{2, 4, 6, 8, 10, 10, 10, 10};
      logic [7:0] seen[$];
      int n;
      btn = 1'b0;
      repeat (40) @(negedge clk);
      btn = 1'b1;
      n = 0;
      while (seen.size() < 8 && n < 80) begin
         @(negedge clk); n++;
         checks++;
         if ({tick, jump_dist, charging, released} !== m_out()) begin
            errors++;
            $display("FAIL sat_lockstep t=%0t got %h exp %h", $time, {tick, jump_dist, charging, released}, m_out());
         end
         if (tick && charging) seen.push_back(jump_dist);
      end
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (k >= seen.size() || seen[k] !== 8'(exp_sat[k])) begin
            errors++;
            $display("FAIL sat_ramp step %0d got %0d exp %0d", k, (k < seen.size()) ? seen[k] : 8'd0, exp_sat[k]);
         end
      end
      btn = 1'b0;
      n = 0;
      while (released !== 1'b1 && n < 40) begin @(negedge clk); n++; end
      checks++;
      if (released !== 1'b1 || jump_dist !== 8'(MX)) begin
         errors++;
         $display("FAIL sat_hold got rel=%b jd=%0d exp rel=1 jd=%0d", released, jump_dist, MX);
      end
      n = 0;
      do begin @(negedge clk); n++; end while (tick !== 1'b1 && n < 10);
      checks++;
      if (jump_dist !== 8'd0) begin errors++; $display("FAIL sat_drop got %0d exp 0", jump_dist); end
   endtask

   task automatic test_glitch();
      btn = 1'b0;
      repeat (40) @(negedge clk);
      btn = 1'b1;
      repeat (2) @(negedge clk);
      btn = 1'b0;
      repeat (30) begin
         @(negedge clk);
         checks++;
         if (charging !== 1'b0 || jump_dist !== 8'd0) begin
            errors++;
            $display("FAIL glitch_ignored got chg=%b jd=%0d exp chg=0 jd=0", charging, jump_dist);
         end
         checks++;
         if ({tick, jump_dist, charging, released} !== m_out()) begin
            errors++;
            $display("FAIL glitch_lockstep t=%0t got %h exp %h", $time, {tick, jump_dist, charging, released}, m_out());
         end
      end
   endtask

   task automatic test_hold_cooldown();
      int n;
      btn = 1'b0;
      repeat (40) @(negedge clk);
      btn = 1'b1;
      n = 0;
      while (charging !== 1'b1 && n < 40) begin @(negedge clk); n++; end
      repeat (TD) @(negedge clk);
      btn = 1'b0;
      n = 0;
      while (released !== 1'b1 && n < 40) begin @(negedge clk); n++; end
      checks++;
      if (released !== 1'b1) begin errors++; $display("FAIL hc_release got 0 exp 1"); end
      btn = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (tick !== 1'b1 && n < 10);
      repeat (40) begin
         @(negedge clk);
         checks++;
         if (charging !== 1'b0 || jump_dist !== 8'd0) begin
            errors++;
            $display("FAIL hc_held_lockout got chg=%b jd=%0d exp chg=0 jd=0", charging, jump_dist);
         end
         checks++;
         if ({tick, jump_dist, charging, released} !== m_out()) begin
            errors++;
            $display("FAIL hc_lockstep t=%0t got %h exp %h", $time, {tick, jump_dist, charging, released}, m_out());
         end
      end
      btn = 1'b0;
      repeat (12) @(negedge clk);
      btn = 1'b1;
      n = 0;
      while (charging !== 1'b1 && n < 40) begin @(negedge clk); n++; end
      checks++;
      if (charging !== 1'b1 || jump_dist !== 8'(ST)) begin
         errors++;
         $display("FAIL hc_recharge got chg=%b jd=%0d exp chg=1 jd=%0d", charging, jump_dist, ST);
      end
      btn = 1'b0;
   endtask

   task automatic test_dead_lock();
      int n;
      bit hit;
      btn = 1'b0;
      repeat (40) @(negedge clk);
      btn = 1'b1;
      n = 0; hit = 0;
      while (!hit && n < 60) begin
         @(negedge clk); n++;
         if (tick && jump_dist === 8'd6) hit = 1;
      end
      checks++;
      if (!hit) begin errors++; $display("FAIL dead_reach6 got %0d exp 6", jump_dist); end
      dead = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (tick !== 1'b1 && n < 10);
      checks++;
      if (jump_dist !== 8'd0 || charging !== 1'b0) begin
         errors++;
         $display("FAIL dead_lock got jd=%0d chg=%b exp jd=0 chg=0", jump_dist, charging);
      end
      for (int c = 0; c < 32; c++) begin
         if (c == 16) dead = 1'b0;
         @(negedge clk);
         checks++;
         if (charging !== 1'b0 || jump_dist !== 8'd0) begin
            errors++;
            $display("FAIL dead_stays_locked got chg=%b jd=%0d exp chg=0 jd=0", charging, jump_dist);
         end
         checks++;
         if ({tick, jump_dist, charging, released} !== m_out()) begin
            errors++;
            $display("FAIL dead_lockstep t=%0t got %h exp %h", $time, {tick, jump_dist, charging, released}, m_out());
         end
      end
      restart = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({tick, jump_dist, charging, released} !== 11'd0) begin
         errors++;
         $display("FAIL dead_restart got %h exp 000", {tick, jump_dist, charging, released});
      end
      restart = 1'b0;
      n = 0;
      while (charging !== 1'b1 && n < 40) begin @(negedge clk); n++; end
      checks++;
      if (charging !== 1'b1 || jump_dist !== 8'(ST)) begin
         errors++;
         $display("FAIL dead_recharge got chg=%b jd=%0d exp chg=1 jd=%0d", charging, jump_dist, ST);
      end
      btn = 1'b0;
   endtask

   task automatic test_random();
      int dur;
      for (int s = 0; s < 80; s++) begin
         btn     = 1'($urandom_range(0, 1));
         dead    = ($urandom_range(0, 24) == 0);
         restart = ($urandom_range(0, 14) == 0);
         dur     = $urandom_range(1, 40);
         for (int c = 0; c < dur; c++) begin
            @(negedge clk);
            checks++;
            if ({tick, jump_dist, charging, released} !== m_out()) begin
               errors++;
               $display("FAIL random_lockstep t=%0t got %h exp %h", $time, {tick, jump_dist, charging, released}, m_out());
            end
            restart = 1'b0;
         end
      end
      btn = 1'b0; dead = 1'b0; restart = 1'b0;
   endtask

   initial begin
      test_reset();
      test_charge_release();
      test_saturation();
      test_glitch();
      test_hold_cooldown();
      test_dead_lock();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
